// File: rtl/cordic_pkg.sv
// Shared CORDIC widths, angle type and the offline-derived arctangent tables.
// Latency: n/a (constants only); backpressure: n/a.
// Build option CORDIC_ATAN_DEG_EN selects the degree Q16.16 table instead of radian Q2.30.
package cordic_pkg;

   localparam int ANGLE_W    = 32;
   localparam int IDX_W      = 32;
   localparam int ATAN_DEPTH = 32;

   typedef logic signed [ANGLE_W-1:0] angle_t;
   typedef logic        [IDX_W-1:0]   idx_t;

   // atan(2^-i) in radians, Q2.30, truncated toward zero.
   localparam angle_t ATAN_RAD_TBL [ATAN_DEPTH] = '{
      32'sd843314856, 32'sd497837829, 32'sd263043836, 32'sd133525158,
      32'sd67021686,  32'sd33543515,  32'sd16775850,  32'sd8388437,
      32'sd4194282,   32'sd2097149,   32'sd1048575,   32'sd524287,
      32'sd262143,    32'sd131071,    32'sd65535,     32'sd32767,
      32'sd16383,     32'sd8191,      32'sd4095,      32'sd2047,
      32'sd1023,      32'sd511,       32'sd255,       32'sd127,
      32'sd63,        32'sd31,        32'sd15,        32'sd7,
      32'sd3,         32'sd1,         32'sd0,         32'sd0
   };

   // atan(2^-i) in degrees, Q16.16, truncated toward zero.
   localparam angle_t ATAN_DEG_TBL [ATAN_DEPTH] = '{
      32'sd2949120,   32'sd1740967,   32'sd919879,    32'sd466945,
      32'sd234378,    32'sd117303,    32'sd58666,     32'sd29334,
      32'sd14667,     32'sd7333,      32'sd3666,      32'sd1833,
      32'sd916,       32'sd458,       32'sd229,       32'sd114,
      32'sd57,        32'sd28,        32'sd14,        32'sd7,
      32'sd3,         32'sd1,         32'sd0,         32'sd0,
      32'sd0,         32'sd0,         32'sd0,         32'sd0,
      32'sd0,         32'sd0,         32'sd0,         32'sd0
   };

`ifdef CORDIC_ATAN_DEG_EN
   localparam angle_t ATAN_TBL [ATAN_DEPTH] = ATAN_DEG_TBL;
`else
   localparam angle_t ATAN_TBL [ATAN_DEPTH] = ATAN_RAD_TBL;
`endif

   // Any index with a bit set above the table range maps to zero; no wrap.
   function automatic angle_t atan_lookup(input idx_t idx);
      angle_t val;
      val = '0;
      if (idx[IDX_W-1:5] == '0) begin
         val = ATAN_TBL[idx[4:0]];
      end
      return val;
   endfunction

endpackage

// File: rtl/cordic_atan_rom_if.sv
// Lookup bus between the CORDIC iteration block and the arctangent table.
// Latency: n/a (wiring); backpressure: none, a lookup is issued every cycle.
// Signals: i = iteration index (master drives), rom = registered angle (slave drives).
interface cordic_atan_rom_if;
   import cordic_pkg::*;

   idx_t   i;
   angle_t rom;

   modport master (output i, input  rom);
   modport slave  (input  i, output rom);
endinterface

// File: rtl/cordic_atan_rom.sv
// Registered atan(2^-i) constant table for the CORDIC rotation datapath.
// Latency: 1 cycle, result for index sampled at edge N is on rom after edge N; no backpressure or stall.
// Ports: clk, rst (sync, active-high), bus.i in, bus.rom out. Build option CORDIC_ATAN_DEG_EN selects degrees.
module cordic_atan_rom
   import cordic_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   cordic_atan_rom_if.slave   bus
);

   angle_t rom_d;
   angle_t rom_q;

   always_comb begin
      rom_d = atan_lookup(bus.i);
   end

   // Reset wins over the pending lookup so the consumer sees a clean zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         rom_q <= '0;
      end else begin
         rom_q <= rom_d;
      end
   end

   assign bus.rom = rom_q;

endmodule

// File: tb/tb_cordic_atan_rom.sv
// Directed bench for cordic_atan_rom: reset, latency, full sweep, out-of-range, mid-stream reset.
// Latency: checks rom one cycle after each index is presented.
// Expected values are hand-derived constants held locally; honours CORDIC_ATAN_DEG_EN.
module tb_cordic_atan_rom;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   cordic_atan_rom_if bus ();

   cordic_atan_rom dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef CORDIC_ATAN_DEG_EN
   logic [31:0] exp_tbl [32] = '{
      32'd2949120, 32'd1740967, 32'd919879, 32'd466945,
      32'd234378,  32'd117303,  32'd58666,  32'd29334,
      32'd14667,   32'd7333,    32'd3666,   32'd1833,
      32'd916,     32'd458,     32'd229,    32'd114,
      32'd57,      32'd28,      32'd14,     32'd7,
      32'd3,       32'd1,       32'd0,      32'd0,
      32'd0,       32'd0,       32'd0,      32'd0,
      32'd0,       32'd0,       32'd0,      32'd0
   };
`else
   logic [31:0] exp_tbl [32] = '{
      32'd843314856, 32'd497837829, 32'd263043836, 32'd133525158,
      32'd67021686,  32'd33543515,  32'd16775850,  32'd8388437,
      32'd4194282,   32'd2097149,   32'd1048575,   32'd524287,
      32'd262143,    32'd131071,    32'd65535,     32'd32767,
      32'd16383,     32'd8191,      32'd4095,      32'd2047,
      32'd1023,      32'd511,       32'd255,       32'd127,
      32'd63,        32'd31,        32'd15,        32'd7,
      32'd3,         32'd1,         32'd0,         32'd0
   };
`endif

   logic [31:0] oor_vals [5] = '{32'd32, 32'd1000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0020};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
      end
   endtask

   // Advance one edge and sample just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b1;
      bus.i  = 32'd0;

      // Reset held two cycles with i = 0.
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("reset_hold", bus.rom, 32'd0);
      end
      rst = 1'b0;
      tick();
      chk("first_after_reset", bus.rom, exp_tbl[0]);

      // Back-to-back latency.
      bus.i = 32'd1;
      tick();
      chk("latency_i1", bus.rom, exp_tbl[1]);
      bus.i = 32'd2;
      tick();
      chk("latency_i2", bus.rom, exp_tbl[2]);

      // Full sweep plus sign bit.
      for (int k = 0; k < 32; k++) begin
         bus.i = k;
         tick();
         chk($sformatf("sweep_i%0d", k), bus.rom, exp_tbl[k]);
         chk($sformatf("sign_i%0d", k), {31'd0, bus.rom[31]}, 32'd0);
      end

`ifndef CORDIC_ATAN_DEG_EN
      bus.i = 32'd10; tick(); chk("spot_i10", bus.rom, 32'd1048575);
      bus.i = 32'd20; tick(); chk("spot_i20", bus.rom, 32'd1023);
      bus.i = 32'd30; tick(); chk("spot_i30", bus.rom, 32'd0);
`else
      bus.i = 32'd0;  tick(); chk("deg_i0",  bus.rom, 32'd2949120);
      bus.i = 32'd1;  tick(); chk("deg_i1",  bus.rom, 32'd1740967);
      bus.i = 32'd2;  tick(); chk("deg_i2",  bus.rom, 32'd919879);
      bus.i = 32'd40; tick(); chk("deg_i40", bus.rom, 32'd0);
`endif

      // Out of range, each preceded by a nonzero entry so a stale value shows.
      for (int k = 0; k < 5; k++) begin
         bus.i = 32'd0;
         tick();
         chk("oor_pre", bus.rom, exp_tbl[0]);
         bus.i = oor_vals[k];
         tick();
         chk($sformatf("oor_0x%08h", oor_vals[k]), bus.rom, 32'd0);
      end

      // Mid-stream reset at i = 5.
      for (int k = 0; k < 10; k++) begin
         bus.i = k;
         rst   = (k == 5);
         tick();
         chk($sformatf("midrst_i%0d", k), bus.rom, (k == 5) ? 32'd0 : exp_tbl[k]);
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
